// File: rtl/poly_ctrl_pkg.sv
// Shared types and constants for the polynomial load scheduler.
package poly_ctrl_pkg;

   localparam int COEF_W  = 23;
   localparam int POLY_AW = 8;
   localparam int BANK_W  = 3;

   // Even index of the last beat of a polynomial (beat carries idx, idx+1)
   localparam logic [POLY_AW-1:0] POLY_LAST_EVEN = 8'd254;
   localparam logic [3:0]         MAX_POLYS      = 4'd8;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_DRAIN
   } state_e;

   // One write-pipeline stage: a popped beat on its way to the RAM ports
   typedef struct packed {
      logic               valid;
      logic [BANK_W-1:0]  bank;
      logic [POLY_AW-1:0] word;
      logic               last_poly;
      logic               last_cmd;
   } wr_stage_t;

endpackage

// File: rtl/poly_wr_pipe.sv
// Two-stage pipeline aligning write address/flags with the FIFO's
// two-cycle read data latency.
module poly_wr_pipe
   import poly_ctrl_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  wr_stage_t stage_in,
   output wr_stage_t stage_out,
   output logic      s1_valid,
   output logic      s2_valid
);

   wr_stage_t s1_d, s1_q;
   wr_stage_t s2_d, s2_q;

   // Plain shift: stage 1 takes the popped beat, stage 2 follows stage 1
   always_comb begin
      s1_d = stage_in;
      s2_d = s1_q;
   end

   // Stage registers, cleared synchronously so no stale beat survives reset
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q <= '0;
         s2_q <= '0;
      end else begin
         s1_q <= s1_d;
         s2_q <= s2_d;
      end
   end

   assign stage_out = s2_q;
   assign s1_valid  = s1_q.valid;
   assign s2_valid  = s2_q.valid;

endmodule

// File: rtl/poly_load_sched.sv
// Command-driven loader: pops 128 beats per polynomial from the coefficient
// FIFO and writes them into consecutive (wrapping) banks of the coefficient RAM.
module poly_load_sched
   import poly_ctrl_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic [BANK_W-1:0]         cmd_bank_base,
   input  logic [3:0]                cmd_poly_cnt,
   output logic                      cmd_err,
   output logic                      busy,
   input  logic                      Rm_tvalid,
   output logic                      rd_en,
   input  logic [COEF_W-1:0]         data_in_1,
   input  logic [COEF_W-1:0]         data_in_2,
   output logic                      coef_ena,
   output logic                      coef_wea,
   output logic [BANK_W+POLY_AW-1:0] coef_addra,
   output logic [COEF_W-1:0]         coef_dina,
   output logic                      coef_enb,
   output logic                      coef_web,
   output logic [BANK_W+POLY_AW-1:0] coef_addrb,
   output logic [COEF_W-1:0]         coef_dinb,
   output logic                      poly_done,
   output logic [BANK_W-1:0]         poly_idx,
   output logic                      module_done
);

   state_e             state_d, state_q;
   logic [BANK_W-1:0]  base_d, base_q;
   logic [3:0]         cnt_d, cnt_q;
   logic [POLY_AW-1:0] word_ctr_d, word_ctr_q;
   logic [3:0]         poly_ctr_d, poly_ctr_q;
   logic               cmd_err_d, cmd_err_q;
   logic               last_wr_d, last_wr_q;

   wr_stage_t stg_in, stg_out;
   logic      s1_valid, s2_valid;
   logic      wr;

   // FSM next state, counters, FIFO pop and pipeline entry
   always_comb begin
      state_d     = state_q;
      base_d      = base_q;
      cnt_d       = cnt_q;
      word_ctr_d  = word_ctr_q;
      poly_ctr_d  = poly_ctr_q;
      cmd_err_d   = 1'b0;
      cmd_ready   = 1'b0;
      rd_en       = 1'b0;
      module_done = 1'b0;
      stg_in      = '0;
      // Marks the cycle right after the command's final RAM write
      last_wr_d   = stg_out.valid & stg_out.last_cmd;

      case (state_q)
         ST_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               if (cmd_poly_cnt == 4'd0 || cmd_poly_cnt > MAX_POLYS) begin
                  cmd_err_d = 1'b1;
               end else begin
                  base_d     = cmd_bank_base;
                  cnt_d      = cmd_poly_cnt;
                  word_ctr_d = '0;
                  poly_ctr_d = '0;
                  state_d    = ST_LOAD;
               end
            end
         end
         ST_LOAD: begin
            rd_en            = Rm_tvalid;
            stg_in.valid     = Rm_tvalid;
            // 3-bit add wraps past bank 7 back to bank 0
            stg_in.bank      = base_q + poly_ctr_q[BANK_W-1:0];
            stg_in.word      = word_ctr_q;
            stg_in.last_poly = (word_ctr_q == POLY_LAST_EVEN);
            stg_in.last_cmd  = stg_in.last_poly && (poly_ctr_q == 4'(cnt_q - 4'd1));
            if (Rm_tvalid) begin
               if (stg_in.last_poly) begin
                  word_ctr_d = '0;
                  poly_ctr_d = poly_ctr_q + 4'd1;
                  if (stg_in.last_cmd) state_d = ST_DRAIN;
               end else begin
                  word_ctr_d = word_ctr_q + 8'd2;
               end
            end
         end
         ST_DRAIN: begin
            if (!s1_valid && !s2_valid && last_wr_q) begin
               module_done = 1'b1;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Nothing is accepted, popped or signalled while reset is asserted
      if (rst) begin
         cmd_ready    = 1'b0;
         rd_en        = 1'b0;
         module_done  = 1'b0;
         stg_in.valid = 1'b0;
      end
   end

   // State and counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         base_q     <= '0;
         cnt_q      <= '0;
         word_ctr_q <= '0;
         poly_ctr_q <= '0;
         cmd_err_q  <= 1'b0;
         last_wr_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         cnt_q      <= cnt_d;
         word_ctr_q <= word_ctr_d;
         poly_ctr_q <= poly_ctr_d;
         cmd_err_q  <= cmd_err_d;
         last_wr_q  <= last_wr_d;
      end
   end

   poly_wr_pipe u_pipe (
      .clk       (clk),
      .rst       (rst),
      .stage_in  (stg_in),
      .stage_out (stg_out),
      .s1_valid  (s1_valid),
      .s2_valid  (s2_valid)
   );

   // A beat still in stage 2 when reset is sampled must not reach the RAM
   assign wr          = stg_out.valid & ~rst;
   assign coef_ena    = wr;
   assign coef_wea    = wr;
   assign coef_enb    = wr;
   assign coef_web    = wr;
   assign coef_addra  = {stg_out.bank, stg_out.word};
   assign coef_addrb  = {stg_out.bank, stg_out.word | 8'd1};
   assign coef_dina   = data_in_1;
   assign coef_dinb   = data_in_2;
   assign poly_done   = wr & stg_out.last_poly;
   assign poly_idx    = stg_out.bank;
   assign busy        = (state_q != ST_IDLE);
   assign cmd_err     = cmd_err_q;

endmodule

// File: tb/tb_poly_load_sched.sv
// Randomized self-checking bench for poly_load_sched against a
// command-level model (expected write list per accepted command).
module tb_poly_load_sched;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [2:0]  cmd_bank_base = '0;
   logic [3:0]  cmd_poly_cnt = '0;
   logic        cmd_err, busy;
   logic        Rm_tvalid = 1'b0;
   logic        rd_en;
   logic [22:0] data_in_1 = '0, data_in_2 = '0;
   logic        coef_ena, coef_wea, coef_enb, coef_web;
   logic [10:0] coef_addra, coef_addrb;
   logic [22:0] coef_dina, coef_dinb;
   logic        poly_done;
   logic [2:0]  poly_idx;
   logic        module_done;

   int n_chk = 0, n_pass = 0, cyc = 0;
   logic [45:0] hist0 = '0, hist1 = '0;

   always #5 clk = ~clk;

   poly_load_sched dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_bank_base(cmd_bank_base), .cmd_poly_cnt(cmd_poly_cnt),
      .cmd_err(cmd_err), .busy(busy), .Rm_tvalid(Rm_tvalid), .rd_en(rd_en),
      .data_in_1(data_in_1), .data_in_2(data_in_2),
      .coef_ena(coef_ena), .coef_wea(coef_wea), .coef_addra(coef_addra),
      .coef_dina(coef_dina), .coef_enb(coef_enb), .coef_web(coef_web),
      .coef_addrb(coef_addrb), .coef_dinb(coef_dinb),
      .poly_done(poly_done), .poly_idx(poly_idx), .module_done(module_done)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
   endtask

   // Start a cycle: just after the edge, present FIFO data popped two cycles ago
   task automatic cyc_begin();
      @(posedge clk);
      #1;
      cyc++;
      {data_in_1, data_in_2} = hist1;
   endtask

   task automatic hist_step(input bit popped, input logic [45:0] v);
      logic [63:0] r;
      r = {$urandom, $urandom};
      hist1 = hist0;
      hist0 = popped ? v : r[45:0];
   endtask

   task automatic run_cmd(input int base, input int cnt, input int pct,
                          input bit hold, input int rst_at);
      int          total;
      logic [10:0] exp_addr[$];
      logic [45:0] exp_dat[$];
      int          pop_cyc[$];
      int          npop, nwr, npd, acc_cyc, last_wr_cyc, md_cyc;
      bit          done, popped, exp_wr, exp_rd, exp_md, exp_pd;
      logic [45:0] v;
      logic [63:0] r;
      total = cnt * 128;
      npop = 0; nwr = 0; npd = 0; acc_cyc = 0; last_wr_cyc = -10; md_cyc = -1; done = 0;
      for (int p = 0; p < cnt; p++)
         for (int k = 0; k < 128; k++)
            exp_addr.push_back(11'(((base + p) % 8) * 256 + 2 * k));

      for (int it = 0; it < 6000 && !done; it++) begin
         cyc_begin();
         cmd_valid     = (it == 0) || hold;
         cmd_bank_base = 3'(base);
         cmd_poly_cnt  = 4'(cnt);
         Rm_tvalid     = ($urandom_range(99) < pct);
         @(negedge clk);
         if (it == 0) begin
            chk("acc_rdy", 32'(cmd_ready), 1);
            acc_cyc = cyc;
         end
         exp_rd = (it > 0 && npop < total) ? Rm_tvalid : 1'b0;
         chk("rd_en", 32'(rd_en), 32'(exp_rd));
         popped = 0;
         v = '0;
         if (rd_en) begin
            npop++;
            r = {$urandom, $urandom};
            v = r[45:0];
            exp_dat.push_back(v);
            pop_cyc.push_back(cyc);
            popped = 1;
         end
         exp_wr = (pop_cyc.size() > 0) && (pop_cyc[0] == cyc - 2);
         chk("wr_en", 32'(coef_ena), 32'(exp_wr));
         if (poly_done) npd++;
         if (exp_wr) begin
            exp_pd = (nwr % 128 == 127);
            chk("addra", 32'(coef_addra), 32'(exp_addr[nwr]));
            chk("addrb", 32'(coef_addrb), 32'(exp_addr[nwr] | 11'd1));
            chk("dina", 32'(coef_dina), 32'(exp_dat[0][45:23]));
            chk("dinb", 32'(coef_dinb), 32'(exp_dat[0][22:0]));
            chk("en_we", 32'({coef_enb, coef_wea, coef_web}), 32'h7);
            chk("poly_done", 32'(poly_done), 32'(exp_pd));
            if (exp_pd) chk("poly_idx", 32'(poly_idx), 32'((base + nwr / 128) % 8));
            nwr++;
            last_wr_cyc = cyc;
            void'(pop_cyc.pop_front());
            void'(exp_dat.pop_front());
         end else begin
            chk("pd_idle", 32'(poly_done), 0);
         end
         exp_md = (nwr == total) && (cyc == last_wr_cyc + 1);
         chk("mod_done", 32'(module_done), 32'(exp_md));
         if (module_done) begin
            done = 1;
            md_cyc = cyc;
         end
         if (rst_at >= 0 && npop == rst_at) break;
         hist_step(popped, v);
      end

      if (rst_at >= 0) begin
         cyc_begin();
         rst = 1'b1; cmd_valid = 1'b0; Rm_tvalid = 1'b1;
         @(negedge clk);
         chk("rst_wr", 32'(coef_ena), 0);
         chk("rst_rd", 32'(rd_en), 0);
         chk("rst_rdy", 32'(cmd_ready), 0);
         cyc_begin();
         rst = 1'b0; Rm_tvalid = 1'b0;
         @(negedge clk);
         chk("rel_rdy", 32'(cmd_ready), 1);
         chk("rel_busy", 32'(busy), 0);
         for (int i = 0; i < 3; i++) begin
            chk("rel_wr", 32'(coef_ena | coef_enb), 0);
            cyc_begin();
            @(negedge clk);
         end
         return;
      end

      chk("done", 32'(done), 1);
      chk("npop", 32'(npop), 32'(total));
      chk("nwr", 32'(nwr), 32'(total));
      chk("npd", 32'(npd), 32'(cnt));
      if (pct == 100) chk("md_lat", 32'(md_cyc - acc_cyc), 32'(128 * cnt + 3));
      cyc_begin();
      cmd_valid = 1'b0; Rm_tvalid = 1'b1;
      @(negedge clk);
      chk("post_rdy", 32'(cmd_ready), 1);
      chk("post_busy", 32'(busy), 0);
      chk("post_rd", 32'(rd_en), 0);
   endtask

   task automatic bad_cmd(input int cnt);
      cyc_begin();
      cmd_valid = 1'b1; cmd_poly_cnt = 4'(cnt); cmd_bank_base = 3'd2; Rm_tvalid = 1'b1;
      @(negedge clk);
      chk("bad_rdy", 32'(cmd_ready), 1);
      chk("bad_rd0", 32'(rd_en), 0);
      cyc_begin();
      cmd_valid = 1'b0;
      @(negedge clk);
      chk("bad_err", 32'(cmd_err), 1);
      chk("bad_busy", 32'(busy), 0);
      chk("bad_rd1", 32'(rd_en), 0);
      cyc_begin();
      @(negedge clk);
      chk("bad_err_clr", 32'(cmd_err), 0);
      chk("bad_busy2", 32'(busy), 0);
      chk("bad_rd2", 32'(rd_en), 0);
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         cyc_begin();
         @(negedge clk);
         chk("rst_ready", 32'(cmd_ready), 0);
      end
      cyc_begin();
      rst = 1'b0; Rm_tvalid = 1'b1;
      @(negedge clk);
      chk("init_ready", 32'(cmd_ready), 1);
      chk("init_busy", 32'(busy), 0);
      chk("init_err", 32'(cmd_err), 0);
      chk("init_rd", 32'(rd_en), 0);
      chk("init_en", 32'({coef_ena, coef_enb, coef_wea, coef_web}), 0);
      chk("init_addr", 32'({coef_addra, poly_idx}), 0);
      chk("init_done", 32'({poly_done, module_done}), 0);

      run_cmd(0, 1, 100, 0, -1);
      run_cmd(6, 4, 100, 0, -1);
      run_cmd(int'($urandom_range(7)), 2, 50, 0, -1);
      bad_cmd(0);
      bad_cmd(9);
      bad_cmd(15);
      run_cmd(3, 2, 100, 0, 50);
      run_cmd(0, 1, 70, 0, -1);
      run_cmd(5, 3, 60, 1, -1);
      run_cmd(int'($urandom_range(7)), int'($urandom_range(1, 8)), 80, 0, -1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
